// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the BUFGMUX select through a quiesce handshake,
// a settle delay and timeout supervision, on the free-running reference clock.
module clk_switch_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned HOLD_TIMEOUT  = 255,
    parameter int unsigned CNT_W         = 8,
    parameter logic        RESET_SEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_sel,
    input  logic hold_ack,
    output logic sel,
    output logic hold_req,
    output logic busy,
    output logic done,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_SWITCH,
        S_SETTLE,
        S_RELEASE
    } state_e;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(HOLD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic             pend_q, pend_d;
    logic             pend_sel_q, pend_sel_d;
    logic             tgt_q, tgt_d;
    logic             start;
    logic             start_sel;
    logic             cnt_last;

    // Counter hits zero on this edge once it has decremented down to one.
    assign cnt_last  = (cnt_q <= CNT_ONE);
    assign start     = req_valid | pend_q;
    assign start_sel = req_valid ? req_sel : pend_sel_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        terr_d     = terr_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        tgt_d      = tgt_q;

        if (req_valid && (state_q != S_IDLE)) begin
            pend_d     = 1'b1;
            pend_sel_d = req_sel;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pend_d = 1'b0;
                    terr_d = 1'b0;
                    if (start_sel != sel_q) begin
                        state_d = S_HOLD;
                        hold_d  = 1'b1;
                        cnt_d   = TMO_LD;
                        tgt_d   = start_sel;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_ack) begin
                    state_d = S_SWITCH;
                end else if (cnt_last) begin
                    hold_d  = 1'b0;
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SWITCH: begin
                sel_d   = tgt_q;
                cnt_d   = SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_last) begin
                    hold_d  = 1'b0;
                    cnt_d   = TMO_LD;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RELEASE: begin
                // The switch already happened, so a stuck ack still completes.
                if (!hold_ack) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_last) begin
                    done_d  = 1'b1;
                    terr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) | pend_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_q      <= RESET_SEL;
            hold_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            tgt_q      <= RESET_SEL;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            tgt_q      <= tgt_d;
        end
    end

    assign sel         = sel_q;
    assign hold_req    = hold_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule
